// File: rtl/fifo_param_pkg.sv
// Shared sizing helpers for the parameterised FIFO.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package fifo_param_pkg;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers need at least one bit even when DEPTH would round to zero.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_param_mem.sv
// DEPTH x W register array with one write port and an asynchronous read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the caller gates wr_en.
module fifo_param_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 9,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_ptr,
    input  logic [W-1:0]  wr_dat,
    input  logic [PW-1:0] rd_ptr,
    output logic [W-1:0]  rd_dat
);

    // Storage is intentionally not reset; validity is tracked by the counter.
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO, any depth, with count, almost flags, optional fall-through and parity check.
// Latency: one cycle push-to-pop (zero when FALLTHROUGH=1 and empty).
// Backpressure: push_grant_o low when full or flushing; head held until pop_grant_i.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int AF_LEVEL    = 3,
    parameter int AE_LEVEL    = 1,
    parameter int FALLTHROUGH = 0,
    parameter int PARITY_EN   = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush_i,
    input  logic                          push_valid_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          push_parity_i,
    output logic                          push_grant_o,
    output logic                          pop_valid_o,
    output logic [DATA_WIDTH-1:0]         pop_data_o,
    input  logic                          pop_grant_i,
    output logic                          parity_err_o,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o
);

    localparam int CW = fifo_cnt_w(DEPTH);
    localparam int PW = fifo_ptr_w(DEPTH);

    typedef struct packed {
        logic                  parity;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    entry_t        wr_entry;
    entry_t        rd_entry;
    entry_t        head;
    logic          empty;
    logic          ft_path;
    logic          push_fire;
    logic          pop_fire;
    logic          bypass;
    logic          wr_en;
    logic          rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_entry = '{parity: push_parity_i, data: push_data_i};

    fifo_param_mem #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t)),
        .PW    (PW)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_ptr (wr_ptr),
        .wr_dat (wr_entry),
        .rd_ptr (rd_ptr),
        .rd_dat (rd_entry)
    );

    assign empty   = (cnt == '0);
    assign ft_path = (FALLTHROUGH != 0) && empty;

    assign push_grant_o = (cnt < CW'(DEPTH)) && !flush_i;
    assign pop_valid_o  = ft_path ? (push_valid_i && !flush_i) : (!empty && !flush_i);
    assign head         = ft_path ? wr_entry : rd_entry;
    assign pop_data_o   = pop_valid_o ? head.data : '0;
    assign parity_err_o = (PARITY_EN != 0) && pop_valid_o && (^head);

    assign push_fire = push_valid_i && push_grant_o;
    assign pop_fire  = pop_valid_o && pop_grant_i;
    // A word forwarded straight through an empty FIFO never touches storage.
    assign bypass    = ft_path && pop_fire;
    assign wr_en     = push_fire && !bypass;
    assign rd_en     = pop_fire && !bypass;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_en && !rd_en) begin
                cnt <= cnt + CW'(1);
            end else if (rd_en && !wr_en) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign count_o        = cnt;
    assign almost_full_o  = (cnt >= CW'(AF_LEVEL));
    assign almost_empty_o = (cnt <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: default, DEPTH=3 and fall-through instances against directed vectors.
// The default instance is also tracked every cycle by a queue model of the FIFO rules.
module tb_fifo_param;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults
    logic       a_flush, a_pv_in, a_pp, a_pg;
    logic [7:0] a_pd, a_pdo;
    logic       a_grant, a_pvo, a_perr, a_af, a_ae;
    logic [2:0] a_cnt;

    // Instance B: DEPTH=3
    logic       b_flush, b_pv_in, b_pp, b_pg;
    logic [7:0] b_pd, b_pdo;
    logic       b_grant, b_pvo, b_perr, b_af, b_ae;
    logic [1:0] b_cnt;

    // Instance C: fall-through
    logic       c_flush, c_pv_in, c_pp, c_pg;
    logic [7:0] c_pd, c_pdo;
    logic       c_grant, c_pvo, c_perr, c_af, c_ae;
    logic [2:0] c_cnt;

    fifo_param u_a (
        .clk(clk), .reset_n(reset_n), .flush_i(a_flush),
        .push_valid_i(a_pv_in), .push_data_i(a_pd), .push_parity_i(a_pp), .push_grant_o(a_grant),
        .pop_valid_o(a_pvo), .pop_data_o(a_pdo), .pop_grant_i(a_pg), .parity_err_o(a_perr),
        .count_o(a_cnt), .almost_full_o(a_af), .almost_empty_o(a_ae)
    );

    fifo_param #(.DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(0)) u_b (
        .clk(clk), .reset_n(reset_n), .flush_i(b_flush),
        .push_valid_i(b_pv_in), .push_data_i(b_pd), .push_parity_i(b_pp), .push_grant_o(b_grant),
        .pop_valid_o(b_pvo), .pop_data_o(b_pdo), .pop_grant_i(b_pg), .parity_err_o(b_perr),
        .count_o(b_cnt), .almost_full_o(b_af), .almost_empty_o(b_ae)
    );

    fifo_param #(.FALLTHROUGH(1)) u_c (
        .clk(clk), .reset_n(reset_n), .flush_i(c_flush),
        .push_valid_i(c_pv_in), .push_data_i(c_pd), .push_parity_i(c_pp), .push_grant_o(c_grant),
        .pop_valid_o(c_pvo), .pop_data_o(c_pdo), .pop_grant_i(c_pg), .parity_err_o(c_perr),
        .count_o(c_cnt), .almost_full_o(c_af), .almost_empty_o(c_ae)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of instance A: a queue of {parity,data} words, DEPTH 4.
    logic [8:0] mq[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
        end else if (a_flush) begin
            mq.delete();
        end else begin
            int  n;
            bit  do_pop;
            bit  do_push;
            n       = mq.size();
            do_pop  = (n != 0) && a_pg;
            do_push = a_pv_in && (n < 4);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({a_pp, a_pd});
        end
    end

    always @(negedge clk) begin
        int         n;
        logic [8:0] h;
        logic       v;
        n = mq.size();
        v = (n != 0) && !a_flush;
        h = 9'h0;
        if (v) h = mq[0];
        chk("m_count", 32'(a_cnt), 32'(n));
        chk("m_grant", 32'(a_grant), 32'((n < 4) && !a_flush));
        chk("m_valid", 32'(a_pvo), 32'(v));
        chk("m_data",  32'(a_pdo), 32'(h[7:0]));
        chk("m_perr",  32'(a_perr), 32'(v && (^h)));
        chk("m_af",    32'(a_af), 32'(n >= 3));
        chk("m_ae",    32'(a_ae), 32'(n <= 1));
    end

    initial begin
        reset_n = 1'b0;
        {a_flush, a_pv_in, a_pp, a_pg, a_pd} = '0;
        {b_flush, b_pv_in, b_pp, b_pg, b_pd} = '0;
        {c_flush, c_pv_in, c_pp, c_pg, c_pd} = '0;
        step();
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_valid", 32'(a_pvo), 0);
        chk("rst_grant", 32'(a_grant), 1);
        chk("rst_ae", 32'(a_ae), 1);
        chk("rst_af", 32'(a_af), 0);
        chk("rst_perr", 32'(a_perr), 0);
        chk("rst_data", 32'(a_pdo), 0);
        chk("rst_c_count", 32'(c_cnt), 0);
        step();
        reset_n = 1'b1;
        step();

        // Fill A with 0x01..0x04, consumer stalled
        for (int i = 1; i <= 4; i++) begin
            a_pv_in = 1'b1;
            a_pd    = 8'(i);
            a_pp    = ^a_pd;
            step();
            chk("fill_count", 32'(a_cnt), 32'(i));
            chk("fill_af", 32'(a_af), (i >= 3) ? 1 : 0);
            chk("fill_grant", 32'(a_grant), (i < 4) ? 1 : 0);
        end
        a_pd = 8'h05;
        a_pp = ^a_pd;
        chk("full_refuse_grant", 32'(a_grant), 0);
        step();
        chk("full_hold_count", 32'(a_cnt), 4);
        a_pv_in = 1'b0;

        // Drain in order
        a_pg = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 32'(a_pvo), 1);
            chk("drain_data", 32'(a_pdo), 32'(i));
            step();
        end
        chk("drained_valid", 32'(a_pvo), 0);
        chk("drained_ae", 32'(a_ae), 1);
        chk("drained_count", 32'(a_cnt), 0);
        a_pg = 1'b0;

        // Parity: 0x03 with wrong parity bit, then 0x07 with correct parity
        a_pv_in = 1'b1;
        a_pd = 8'h03; a_pp = 1'b1;
        step();
        a_pd = 8'h07; a_pp = 1'b1;
        step();
        a_pv_in = 1'b0;
        a_pg = 1'b1;
        chk("par_bad_err", 32'(a_perr), 1);
        chk("par_bad_data", 32'(a_pdo), 32'h03);
        step();
        chk("par_ok_err", 32'(a_perr), 0);
        chk("par_ok_data", 32'(a_pdo), 32'h07);
        step();
        a_pg = 1'b0;

        // Concurrent push/pop on A, checked by the model
        a_pv_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_pd = 8'h40 + 8'(i);
            a_pp = ^a_pd;
            a_pg = (i >= 2);
            step();
        end
        a_pv_in = 1'b0;
        a_pg = 1'b1;
        repeat (3) step();
        a_pg = 1'b0;

        // DEPTH=3 streaming with wrap
        b_pv_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_pd = 8'h10 + 8'(i);
            b_pp = ^b_pd;
            b_pg = (i >= 2);
            if (i >= 2) begin
                #1;
                chk("wrap_data", 32'(b_pdo), 32'h10 + 32'(i - 2));
                chk("wrap_count", 32'(b_cnt), 2);
            end
            step();
        end
        b_pv_in = 1'b0;
        b_pg = 1'b1;
        #1;
        chk("wrap_tail0", 32'(b_pdo), 32'h1E);
        step();
        chk("wrap_tail1", 32'(b_pdo), 32'h1F);
        step();
        chk("wrap_empty", 32'(b_pvo), 0);
        b_pg = 1'b0;

        // Fall-through on empty
        c_pv_in = 1'b1; c_pd = 8'hA5; c_pp = ^c_pd; c_pg = 1'b1;
        #1;
        chk("ft_valid", 32'(c_pvo), 1);
        chk("ft_data", 32'(c_pdo), 32'hA5);
        chk("ft_perr", 32'(c_perr), 0);
        step();
        c_pv_in = 1'b0;
        #1;
        chk("ft_count", 32'(c_cnt), 0);
        chk("ft_idle_valid", 32'(c_pvo), 0);
        c_pv_in = 1'b1; c_pd = 8'h03; c_pp = 1'b1;
        #1;
        chk("ft_bad_perr", 32'(c_perr), 1);
        step();
        c_pg = 1'b0; c_pd = 8'h5A; c_pp = ^c_pd;
        step();
        c_pv_in = 1'b0;
        #1;
        chk("ft_store_count", 32'(c_cnt), 1);
        chk("ft_store_data", 32'(c_pdo), 32'h5A);
        c_pg = 1'b1;
        step();
        chk("ft_store_drained", 32'(c_cnt), 0);
        c_pg = 1'b0;

        // Flush with three entries held
        a_pv_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_pd = 8'h81 + 8'(i);
            a_pp = ^a_pd;
            step();
        end
        a_pv_in = 1'b0;
        chk("pre_flush_count", 32'(a_cnt), 3);
        a_flush = 1'b1;
        a_pv_in = 1'b1;
        a_pg = 1'b1;
        #1;
        chk("flush_grant", 32'(a_grant), 0);
        chk("flush_valid", 32'(a_pvo), 0);
        step();
        a_flush = 1'b0;
        a_pv_in = 1'b0;
        a_pg = 1'b0;
        #1;
        chk("post_flush_count", 32'(a_cnt), 0);
        chk("post_flush_valid", 32'(a_pvo), 0);

        // Asynchronous reset mid-stream
        a_pv_in = 1'b1;
        a_pd = 8'h91; a_pp = ^a_pd;
        step();
        a_pd = 8'h92; a_pp = ^a_pd;
        step();
        chk("pre_rst_count", 32'(a_cnt), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(a_cnt), 0);
        chk("mid_rst_valid", 32'(a_pvo), 0);
        chk("mid_rst_grant", 32'(a_grant), 1);
        chk("mid_rst_ae", 32'(a_ae), 1);
        chk("mid_rst_af", 32'(a_af), 0);
        chk("mid_rst_perr", 32'(a_perr), 0);
        chk("mid_rst_data", 32'(a_pdo), 0);
        a_pv_in = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
